// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings, data width, bit-period width.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_BAUD_W    = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..P-1 and strobes bit_end on the last cycle.
module uart_baud_cnt
  import uart_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clr_i,
  input  logic                   en_i,
  input  logic [UART_BAUD_W-1:0] period_i,
  output logic                   bit_end_o
);

  logic [UART_BAUD_W-1:0] cnt_q, cnt_d;
  logic [UART_BAUD_W-1:0] last;

  // A period of 0 behaves like 1; no wrap on the subtraction.
  assign last = (period_i == '0) ? '0
              : period_i - UART_BAUD_W'(1);

  assign bit_end_o = en_i && (cnt_q == last);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || bit_end_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + UART_BAUD_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8 data bits LSB-first, 1/2 stop bits, registered outputs.
// Optional parity bit when UART_TX_PARITY_EN is defined.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [UART_BAUD_W-1:0] clks_per_bit_i,
  input  logic                   parity_odd_i,
  input  logic                   tx_valid_i,
  input  logic [7:0]             tx_data_i,
  output logic                   tx_ready_o,
  output logic                   tx_o,
  output logic                   tx_busy_o,
  output logic                   tx_done_o
);

  uart_state_e            state_q, state_d;
  logic [7:0]             shift_q, shift_d;
  logic [2:0]             idx_q, idx_d;
  logic [UART_BAUD_W-1:0] per_q, per_d;
  logic                   stop_q, stop_d;
  logic                   tx_q, tx_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   bit_end;

`ifdef UART_TX_PARITY_EN
  logic                   par_q, par_d;
`else
  logic                   unused_parity;
  assign unused_parity = parity_odd_i;
`endif

  uart_baud_cnt u_baud_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (state_q == IDLE),
    .en_i      (state_q != IDLE),
    .period_i  (per_q),
    .bit_end_o (bit_end)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      per_q   <= '0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      per_q   <= per_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    per_d   = per_q;
    stop_d  = stop_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (tx_valid_i) begin
          shift_d = tx_data_i;
          per_d   = clks_per_bit_i;
          idx_d   = '0;
          stop_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_d   = (^tx_data_i) ^ parity_odd_i;
`endif
          state_d = START;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (STOP_BITS == 1 || stop_q) begin
            state_d = IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with state.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_q;
`endif
      default: tx_d = 1'b1;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    done_d  = (state_q == STOP) && (state_d == IDLE);
  end

  assign tx_o       = tx_q;
  assign tx_ready_o = ready_q;
  assign tx_busy_o  = busy_q;
  assign tx_done_o  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed testbench for uart_tx; frame bits predicted from the byte.
module tb_uart_tx;

  localparam int STOP_BITS = 1;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 10 + STOP_BITS;
`else
  localparam int NB = 9 + STOP_BITS;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [15:0] clks = 16'd4;
  logic        odd = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        ready, tx, busy, done;

  int cmp = 0;
  int err = 0;

  uart_tx #(.STOP_BITS(STOP_BITS)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clks_per_bit_i (clks),
    .parity_odd_i   (odd),
    .tx_valid_i     (valid),
    .tx_data_i      (data),
    .tx_ready_o     (ready),
    .tx_o           (tx),
    .tx_busy_o      (busy),
    .tx_done_o      (done)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic exp_bit(input logic [7:0] d, input logic o,
                                   input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return (^d) ^ o;
`else
    if (o === 1'bz) return 1'bx;
`endif
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    valid  = 1'b0;
    repeat (2) tick();
    cmp++;
    if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      err++;
      $display("FAIL reset_in tx=%b rdy=%b busy=%b done=%b want 1 1 0 0",
               tx, ready, busy, done);
    end
    rst_ni = 1'b1;
    tick();
    cmp++;
    if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      err++;
      $display("FAIL reset_out tx=%b rdy=%b busy=%b done=%b want 1 1 0 0",
               tx, ready, busy, done);
    end
  endtask

  task automatic test_basic();
    logic [7:0] d;
    int p;
    d = 8'hA5;
    p = 4;
    clks = 16'(p);
    odd = 1'b0;
    data = d;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int c = 0; c < NB * p; c++) begin
      cmp++;
      if (tx !== exp_bit(d, 1'b0, c / p) || ready !== 1'b0 ||
          busy !== 1'b1 || done !== 1'b0) begin
        err++;
        $display("FAIL basic c=%0d tx=%b rdy=%b busy=%b done=%b want tx=%b 0 1 0",
                 c + 1, tx, ready, busy, done, exp_bit(d, 1'b0, c / p));
      end
      tick();
    end
    cmp++;
    if (done !== 1'b1 || ready !== 1'b1 || tx !== 1'b1 || busy !== 1'b0) begin
      err++;
      $display("FAIL basic_done done=%b rdy=%b tx=%b busy=%b want 1 1 1 0",
               done, ready, tx, busy);
    end
    tick();
    cmp++;
    if (done !== 1'b0) begin
      err++;
      $display("FAIL basic_pulse done=%b want 0", done);
    end
  endtask

  task automatic test_back_to_back();
    int p;
    int f;
    int dones;
    p = 3;
    f = NB * p;
    dones = 0;
    clks = 16'(p);
    odd = 1'b0;
    data = 8'h00;
    valid = 1'b1;
    tick();
    data = 8'hFF;
    for (int c = 1; c <= 2 * f + 4; c++) begin
      logic et;
      logic ed;
      ed = (c == f + 1) || (c == 2 * f + 2);
      if (c <= f) et = exp_bit(8'h00, 1'b0, (c - 1) / p);
      else if (c >= f + 2 && c <= 2 * f + 1)
        et = exp_bit(8'hFF, 1'b0, (c - f - 2) / p);
      else et = 1'b1;
      if (done === 1'b1) dones++;
      cmp++;
      if (tx !== et || done !== ed) begin
        err++;
        $display("FAIL b2b c=%0d tx=%b done=%b want tx=%b done=%b",
                 c, tx, done, et, ed);
      end
      if (c == f + 2) valid = 1'b0;
      tick();
    end
    cmp++;
    if (dones !== 2) begin
      err++;
      $display("FAIL b2b_dones got=%0d want 2", dones);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    for (int o = 0; o < 2; o++) begin
      logic [7:0] d;
      int p;
      d = 8'h07;
      p = 2;
      clks = 16'(p);
      odd = o[0];
      data = d;
      valid = 1'b1;
      tick();
      valid = 1'b0;
      odd = ~odd;
      for (int c = 0; c < 22; c++) begin
        cmp++;
        if (tx !== exp_bit(d, o[0], c / p) || done !== 1'b0) begin
          err++;
          $display("FAIL parity o=%0d c=%0d tx=%b done=%b want tx=%b",
                   o, c + 1, tx, done, exp_bit(d, o[0], c / p));
        end
        if (c / p == 9) begin
          cmp++;
          if (tx !== (o == 0 ? 1'b1 : 1'b0)) begin
            err++;
            $display("FAIL parity_bit o=%0d tx=%b want %b",
                     o, tx, (o == 0 ? 1'b1 : 1'b0));
          end
        end
        tick();
      end
      cmp++;
      if (done !== 1'b1) begin
        err++;
        $display("FAIL parity_done o=%0d done=%b want 1", o, done);
      end
      tick();
    end
    odd = 1'b0;
  endtask
`endif

  task automatic test_short_period();
    for (int pv = 0; pv < 2; pv++) begin
      logic prev;
      clks = 16'(pv);
      data = 8'h55;
      valid = 1'b1;
      tick();
      valid = 1'b0;
      prev = 1'b0;
      for (int c = 0; c < NB; c++) begin
        cmp++;
        if (tx !== exp_bit(8'h55, 1'b0, c)) begin
          err++;
          $display("FAIL short pv=%0d c=%0d tx=%b want %b",
                   pv, c + 1, tx, exp_bit(8'h55, 1'b0, c));
        end
        if (c >= 1 && c <= 8) begin
          cmp++;
          if (tx === prev) begin
            err++;
            $display("FAIL short_toggle pv=%0d c=%0d tx=%b want %b",
                     pv, c + 1, tx, ~prev);
          end
        end
        prev = tx;
        tick();
      end
      cmp++;
      if (done !== 1'b1) begin
        err++;
        $display("FAIL short_done pv=%0d done=%b want 1", pv, done);
      end
      tick();
    end
  endtask

  task automatic test_mid_change();
    clks = 16'd4;
    data = 8'hC3;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    clks = 16'd8;
    for (int c = 0; c < NB * 4; c++) begin
      cmp++;
      if (tx !== exp_bit(8'hC3, 1'b0, c / 4)) begin
        err++;
        $display("FAIL mid4 c=%0d tx=%b want %b",
                 c + 1, tx, exp_bit(8'hC3, 1'b0, c / 4));
      end
      tick();
    end
    cmp++;
    if (done !== 1'b1) begin
      err++;
      $display("FAIL mid4_done done=%b want 1", done);
    end
    data = 8'h3A;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int c = 0; c < NB * 8; c++) begin
      cmp++;
      if (tx !== exp_bit(8'h3A, 1'b0, c / 8)) begin
        err++;
        $display("FAIL mid8 c=%0d tx=%b want %b",
                 c + 1, tx, exp_bit(8'h3A, 1'b0, c / 8));
      end
      tick();
    end
    cmp++;
    if (done !== 1'b1) begin
      err++;
      $display("FAIL mid8_done done=%b want 1", done);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    clks = 16'd4;
    data = 8'hA5;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (17) tick();
    cmp++;
    if (tx !== 1'b0) begin
      err++;
      $display("FAIL rst_pre tx=%b want 0", tx);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    cmp++;
    if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
      err++;
      $display("FAIL rst_async tx=%b rdy=%b busy=%b want 1 1 0",
               tx, ready, busy);
    end
    tick();
    rst_ni = 1'b1;
    tick();
    cmp++;
    if (ready !== 1'b1 || done !== 1'b0 || tx !== 1'b1) begin
      err++;
      $display("FAIL rst_release rdy=%b done=%b tx=%b want 1 0 1",
               ready, done, tx);
    end
    data = 8'h3C;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int c = 0; c < NB * 4; c++) begin
      cmp++;
      if (tx !== exp_bit(8'h3C, 1'b0, c / 4) || done !== 1'b0) begin
        err++;
        $display("FAIL rst_fresh c=%0d tx=%b done=%b want tx=%b done=0",
                 c + 1, tx, done, exp_bit(8'h3C, 1'b0, c / 4));
      end
      tick();
    end
    cmp++;
    if (done !== 1'b1) begin
      err++;
      $display("FAIL rst_fresh_done done=%b want 1", done);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_short_period();
    test_mid_change();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter, 8 data bits LSB-first, 1 or 2 stop bits, optional parity, runtime-programmable bit period. It sits beside the UART receiver in the UART peripheral. It accepts bytes from the register/FIFO side over a valid/ready handshake and drives the serial line. Its bit timing matches the receiver's: one bit lasts `clks_per_bit_i` clock cycles.

## Interface
- `STOP_BITS`, default 1: stop bits per frame; legal values 1 or 2.
- `clk_i` input, 1 bit: clock.
- `rst_ni` input, 1 bit: reset, asynchronous, active-low.
- `clks_per_bit_i` input, 16 bits: clock cycles per bit, equal to f_clk / baud. Sampled only at byte acceptance.
- `parity_odd_i` input, 1 bit: 1 selects odd parity, 0 selects even. Sampled at acceptance. Ignored unless parity is compiled in.
- `tx_valid_i` input, 1 bit: byte available.
- `tx_data_i` input, 8 bits: byte to send.
- `tx_ready_o` output, 1 bit: transmitter can accept a byte.
- `tx_o` output, 1 bit: serial line; idles high.
- `tx_busy_o` output, 1 bit: a frame is in progress.
- `tx_done_o` output, 1 bit: one-cycle pulse when a frame completes.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. PARITY exists only with the macro. Encoding comes from the shared package.
- IDLE:
  - `tx_ready_o`=1, `tx_o`=1, `tx_busy_o`=0.
  - On `tx_valid_i & tx_ready_o`, latch `tx_data_i` into a shift register and latch `clks_per_bit_i` and `parity_odd_i`.
  - Clear the bit counter and the cycle counter, then go to START.
- START: `tx_o`=0 for one bit period, then go to DATA.
- DATA:
  - `tx_o` = shift register bit 0. Each bit is held one bit period.
  - At the end of each period, shift right and increment the 3-bit index.
  - After index 7 completes, go to PARITY if parity is compiled in, otherwise STOP.
- PARITY: `tx_o` = XOR of the 8 latched data bits, XOR `parity_odd_i`. Held one bit period, then go to STOP.
- STOP:
  - `tx_o`=1 for `STOP_BITS` bit periods.
  - On completion, go to IDLE and pulse `tx_done_o` in that same transition.
- Bit period:
  - The 16-bit cycle counter counts 0 to P-1, where P is the latched period.
  - The bit ends in the cycle where counter == P-1; the counter then wraps to 0.
  - A latched value of 0 is treated as 1. The comparison uses the 16-bit latched value, so there is no overflow.
- `tx_ready_o` is 0 in every state except IDLE. `tx_valid_i` and `tx_data_i` are ignored while busy.
- Changing `clks_per_bit_i` or `parity_odd_i` mid-frame has no effect on the current frame.
- Default branch of the state machine goes to IDLE.

## Timing
- All outputs are registered.
- Reset values: `tx_o`=1, `tx_ready_o`=1, `tx_busy_o`=0, `tx_done_o`=0. State is IDLE and all counters are 0.
- Latency: a byte accepted in cycle T drives the start bit on `tx_o` from cycle T+1.
- Frame length without parity: (1+8+STOP_BITS)·P cycles. Add P cycles when parity is compiled in.
- `tx_done_o` is high in the first IDLE cycle. `tx_ready_o` is 1 in that same cycle.
- Back-to-back: if valid is held high, the next byte is accepted in the first IDLE cycle. Frame-to-frame period is therefore frame length + 1 cycle.
- Reset asserted mid-frame: `tx_o` goes to 1 immediately (asynchronous) and the byte in flight is discarded. No `tx_done_o` pulse.

## Configuration
- Macro `UART_TX_PARITY_EN`.
- Defined: PARITY state present. Frame is start, 8 data bits, parity, stop bit(s). Parity sense follows `parity_odd_i`.
- Undefined: PARITY state and parity logic are removed. Frame is 8N1 or 8N2, and `parity_odd_i` is unconnected internally.

## Structure
- Shared package `uart_pkg` holds:
  - state typedef/encodings: IDLE=3'd0, START=3'd1, DATA=3'd2, PARITY=3'd3, STOP=3'd4;
  - constant `UART_DATA_BITS`=8;
  - the 16-bit width constant for the bit period, shared with the receiver.
- One sub-module, `uart_baud_cnt`:
  - inputs: load/enable and the 16-bit period;
  - output: a `bit_end` strobe when the count reaches P-1.
- The state machine instantiates `uart_baud_cnt` once.

## Test plan
- Reset, then P=4, send 0xA5, no parity.
  - `tx_o` from T+1: 0, then 1,0,1,0,0,1,0,1, then 1; each bit held 4 cycles.
  - `tx_done_o` pulses at T+41. `tx_ready_o`=0 during cycles T+1..T+40.
- Back-to-back 0x00 then 0xFF with valid held, P=3.
  - The second start bit begins exactly 31 cycles after the first.
  - Exactly two `tx_done_o` pulses.
- With `UART_TX_PARITY_EN`, P=2, send 0x07.
  - `parity_odd_i`=0 gives a parity bit of 1; `parity_odd_i`=1 gives 0.
  - Frame is 22 cycles.
- P=0 and P=1: each bit lasts 1 cycle. Sending 0x55 toggles `tx_o` every cycle during the data bits.
- Change `clks_per_bit_i` from 4 to 8 mid-frame: the current frame stays at P=4; the next accepted frame uses 8.
- Assert `rst_ni` low during data bit 3: `tx_o`=1 asynchronously, and `tx_ready_o`=1 after release. A fresh 0x3C then transmits correctly.
